// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus bundle between wb_cmd_master and a single slave.
// Signal names follow the initiator's view (_o driven by the master, _i by the slave).
interface wb_cmd_master_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DATA_BYTES    = 1
);
    logic [ADDRESS_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0]    dat_o;
    logic [DATA_WIDTH-1:0]    dat_i;
    logic                     we_o;
    logic [DATA_BYTES-1:0]    sel_o;
    logic                     stb_o;
    logic                     cyc_o;
    logic                     ack_i;
    logic [2:0]               cti_o;

    modport master (
        output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: buffers single-beat read/write commands
// and replays them onto the bus, one response per command, with an optional
// idle delay after each command.
// Optional feature: define WB_TIMEOUT_EN to abort bus cycles that see no ack
// within TIMEOUT_CYCLES cycles (response flagged with rsp_err_o).
module wb_cmd_master #(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DATA_BYTES     = 1,
    parameter int unsigned DELAY_WIDTH    = 20,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [ADDRESS_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]    cmd_dat_i,
    input  logic [DELAY_WIDTH-1:0]   cmd_delay_i,
    output logic                     rsp_valid_o,
    output logic [DATA_WIDTH-1:0]    rsp_dat_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    wb_cmd_master_if.master          wb_io
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Reject configurations the pointer arithmetic cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("wb_cmd_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DELAY = 2'd2
    } state_t;

    // Command buffer storage and pointers
    logic                     we_mem  [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] adr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    dat_mem [FIFO_DEPTH];
    logic [DELAY_WIDTH-1:0]   dly_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     push, pop;

    // Bus-side registers
    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0]    dat_q;
    logic                     we_q;
    logic                     cyc_q;
    logic [DELAY_WIDTH-1:0]   dly_q;
    logic                     rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_dat_q;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]         tmo_q;
    logic                     rsp_err_q;
`endif

    assign push = cmd_valid_i && cmd_ready_o;
    assign pop  = (state_q == ST_IDLE) && (count_q != '0);

    // Occupancy update; simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Buffer payload storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) begin
            we_mem[wr_ptr_q]  <= cmd_we_i;
            adr_mem[wr_ptr_q] <= cmd_adr_i;
            dat_mem[wr_ptr_q] <= cmd_dat_i;
            dly_mem[wr_ptr_q] <= cmd_delay_i;
        end
    end

    // Command sequencer: launch, wait for ack (or timeout), then post-delay
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            dly_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        adr_q   <= adr_mem[rd_ptr_q];
                        dat_q   <= dat_mem[rd_ptr_q];
                        we_q    <= we_mem[rd_ptr_q];
                        dly_q   <= dly_mem[rd_ptr_q];
                        cyc_q   <= 1'b1;
                        state_q <= ST_BUS;
`ifdef WB_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                ST_BUS: begin
                    if (wb_io.ack_i) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= wb_io.dat_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= (dly_q != '0) ? ST_DELAY : ST_IDLE;
`ifdef WB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= (dly_q != '0) ? ST_DELAY : ST_IDLE;
                    end else begin
                        tmo_q       <= tmo_q + TMO_W'(1);
`endif
                    end
                end
                ST_DELAY: begin
                    if (dly_q == DELAY_WIDTH'(1)) state_q <= ST_IDLE;
                    else                          dly_q   <= dly_q - DELAY_WIDTH'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
    assign busy_o      = (state_q != ST_IDLE) || (count_q != '0);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

    assign wb_io.adr_o = adr_q;
    assign wb_io.dat_o = dat_q;
    assign wb_io.we_o  = we_q;
    assign wb_io.sel_o = '1;
    assign wb_io.stb_o = cyc_q;
    assign wb_io.cyc_o = cyc_q;
    assign wb_io.cti_o = 3'b000;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: vector table + response scoreboard + corner sequences.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_adr = '0;
    logic [7:0]  cmd_dat = '0;
    logic [19:0] cmd_delay = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_dat;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int ack_lat = 1;   // slave acks in this cycle of a bus cycle; 0 = never

    wb_cmd_master_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .DATA_BYTES(1)) wb ();

    wb_cmd_master dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_delay_i (cmd_delay),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .wb_io       (wb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dat;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [7:0]  dat;
        logic [19:0] dly;
        int          lat;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs[6];

    // Slave read-data model: low address byte XOR 0xA5
    function automatic logic [7:0] slave_data(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone slave: ack in cycle ack_lat of each bus cycle; random data otherwise
    initial begin
        int n;
        n = 0;
        wb.ack_i = 1'b0;
        wb.dat_i = '0;
        forever begin
            @(negedge clk);
            if (wb.cyc_o && wb.stb_o && !wb.ack_i) begin
                n++;
                if (ack_lat != 0 && n >= ack_lat) begin
                    wb.ack_i = 1'b1;
                    wb.dat_i = slave_data(wb.adr_o);
                end else begin
                    wb.dat_i = 8'($urandom);
                end
            end else begin
                wb.ack_i = 1'b0;
                wb.dat_i = 8'($urandom);
                n = 0;
            end
        end
    end

    // Response scoreboard and bus invariant monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            chk("cyc_eq_stb", 32'(wb.cyc_o), 32'(wb.stb_o));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_dat", 32'(rsp_dat), 32'(e.dat));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    // Offer one command; returns #1 after the accepting edge
    task automatic push_cmd(input logic we, input logic [15:0] adr, input logic [7:0] dat,
                            input logic [19:0] dly, input logic [7:0] edat, input logic eerr);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_delay = dly;
        cmd_valid = 1'b1;
        exp_q.push_back('{dat: edat, err: eerr});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Count low cycles between the first command's cyc falling and the next rising
    task automatic gap_test(input logic [19:0] dly, input int exp_gap);
        int n;
        ack_lat = 1;
        push_cmd(1'b1, 16'h0300, 8'h11, dly, slave_data(16'h0300), 1'b0);
        push_cmd(1'b1, 16'h0301, 8'h22, 20'd0, slave_data(16'h0301), 1'b0);
        n = 0;
        while (!wb.cyc_o && n < 100) begin @(posedge clk); #1; n++; end
        n = 0;
        while (wb.cyc_o && n < 100) begin @(posedge clk); #1; n++; end
        n = 0;
        while (!wb.cyc_o && n < 1000) begin n++; @(posedge clk); #1; end
        chk("gap_cycles", 32'(n), 32'(exp_gap));
        wait_idle();
    endtask

    initial begin
        int n;
        vecs[0] = '{we: 1'b1, adr: 16'h0104, dat: 8'h31, dly: 20'd0, lat: 2, exp_dat: 8'hA1};
        vecs[1] = '{we: 1'b0, adr: 16'h0100, dat: 8'h00, dly: 20'd0, lat: 1, exp_dat: 8'hA5};
        vecs[2] = '{we: 1'b1, adr: 16'hFFFF, dat: 8'hFF, dly: 20'd0, lat: 3, exp_dat: 8'h5A};
        vecs[3] = '{we: 1'b0, adr: 16'h1234, dat: 8'h77, dly: 20'd2, lat: 1, exp_dat: 8'h91};
        vecs[4] = '{we: 1'b0, adr: 16'h00C3, dat: 8'h00, dly: 20'd3, lat: 4, exp_dat: 8'h66};
        vecs[5] = '{we: 1'b1, adr: 16'h8001, dat: 8'h5A, dly: 20'd1, lat: 1, exp_dat: 8'hA4};

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cyc",       32'(wb.cyc_o),   32'd0);
        chk("rst_stb",       32'(wb.stb_o),   32'd0);
        chk("rst_we",        32'(wb.we_o),    32'd0);
        chk("rst_adr",       32'(wb.adr_o),   32'd0);
        chk("rst_dat",       32'(wb.dat_o),   32'd0);
        chk("rst_sel",       32'(wb.sel_o),   32'd1);
        chk("rst_cti",       32'(wb.cti_o),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_rsp_dat",   32'(rsp_dat),    32'd0);
        chk("rst_rsp_err",   32'(rsp_err),    32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_ready",     32'(cmd_ready),  32'd1);

        // Table-driven single commands with latency and bus-value checks
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            ack_lat = vecs[i].lat;
            push_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].dly, vecs[i].exp_dat, 1'b0);
            chk("v_cyc_pre", 32'(wb.cyc_o), 32'd0);
            @(posedge clk); #1;
            chk("v_cyc_rise", 32'(wb.cyc_o), 32'd1);
            chk("v_adr", 32'(wb.adr_o), 32'(vecs[i].adr));
            chk("v_we",  32'(wb.we_o),  32'(vecs[i].we));
            if (vecs[i].we) chk("v_dat_o", 32'(wb.dat_o), 32'(vecs[i].dat));
            n = 1;
            while (wb.cyc_o && n < 100) begin
                @(posedge clk); #1;
                if (wb.cyc_o) n++;
            end
            chk("v_cyc_len", 32'(n), 32'(vecs[i].lat));
            chk("v_rsp_pulse", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
            chk("v_rsp_single", 32'(rsp_valid), 32'd0);
        end
        wait_idle();

        // Five back-to-back commands into a 4-deep buffer with the slave stalled
        ack_lat = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bb_ready", 32'(cmd_ready), 32'd1);
            cmd_we    = i[0];
            cmd_adr   = 16'h0200 + 16'(i);
            cmd_dat   = 8'(i);
            cmd_delay = '0;
            cmd_valid = 1'b1;
            exp_q.push_back('{dat: slave_data(16'h0200 + 16'(i)), err: 1'b0});
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("bb_full_ready", 32'(cmd_ready), 32'd0);
        chk("bb_busy",       32'(busy),      32'd1);
        chk("bb_cyc",        32'(wb.cyc_o),  32'd1);
        repeat (5) @(posedge clk);
        #1 ack_lat = 2;
        wait_idle();

        // Post-delay spacing between consecutive bus cycles
        gap_test(20'd10, 11);
        gap_test(20'd0, 1);

`ifdef WB_TIMEOUT_EN
        // Timeout with no ack, then ack on the timeout edge
        ack_lat = 0;
        push_cmd(1'b0, 16'h0400, 8'h00, 20'd0, 8'h00, 1'b1);
        @(posedge clk); #1;
        n = 0;
        while (wb.cyc_o && n < 100) begin n++; @(posedge clk); #1; end
        chk("tmo_cyc_len", 32'(n), 32'd15);
        wait_idle();
        ack_lat = 15;
        push_cmd(1'b0, 16'h0401, 8'h00, 20'd0, slave_data(16'h0401), 1'b0);
        @(posedge clk); #1;
        n = 0;
        while (wb.cyc_o && n < 100) begin n++; @(posedge clk); #1; end
        chk("tmo_ack_cyc_len", 32'(n), 32'd15);
        wait_idle();
`endif

        // Reset in the middle of a bus cycle with two commands queued
        ack_lat = 0;
        push_cmd(1'b1, 16'h0500, 8'h01, 20'd0, 8'h00, 1'b0);
        push_cmd(1'b1, 16'h0501, 8'h02, 20'd0, 8'h00, 1'b0);
        push_cmd(1'b1, 16'h0502, 8'h03, 20'd0, 8'h00, 1'b0);
        chk("mid_cyc", 32'(wb.cyc_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc",  32'(wb.cyc_o), 32'd0);
        chk("mid_rst_stb",  32'(wb.stb_o), 32'd0);
        chk("mid_rst_busy", 32'(busy),     32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy",  32'(busy),      32'd0);
        chk("post_rst_cyc",   32'(wb.cyc_o),  32'd0);

        // Recovery after reset
        ack_lat = 1;
        push_cmd(1'b0, 16'h0100, 8'h00, 20'd0, 8'hA5, 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
